wait_event_initiator: RTL and testbench

//  Initiator end of the wait-event interface (wait_en/sel_wtr_wtf/max_timeout/wait_done).
//  - Queues wait commands {signal index, edge, timeout} in a FIFO.
//  - Issues them one at a time to a wait-event responder and guards each with its own timeout counter.
//  - Returns one status record per command.
//  - Lets a hardware sequencer drive the same responders the task-based bench uses.

---
 rtl/wait_event_initiator.sv | 171 +++++++++++++++++
 tb/tb_wait_event_initiator.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wait_event_initiator.sv
// rtl/wait_event_initiator.sv - wait-event initiator: command FIFO, issue FSM, per-command timeout, status return
// Optional abort input is compiled in when WAIT_INIT_ABORT_EN is defined.
module wait_event_initiator #(
  parameter int FIFO_DEPTH = 4,
  parameter int WAIT_SIZE  = 5,
  parameter int SEL_W      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef WAIT_INIT_ABORT_EN
  input  logic             abort,
`endif
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [SEL_W-1:0] cmd_sel,
  input  logic             cmd_rise,
  input  logic [31:0]      cmd_timeout,
  output logic             wait_en,
  output logic             sel_wtr_wtf,
  output logic [31:0]      max_timeout,
  output logic [SEL_W-1:0] wait_sel,
  input  logic             wait_done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_status,
  output logic [SEL_W-1:0] rsp_sel,
  output logic [31:0]      rsp_cycles
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = SEL_W + 33;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] ST_DONE    = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ABORT   = 2'b10;

  if ((1 << SEL_W) < WAIT_SIZE) begin : g_sel_w_check
    $error("SEL_W too narrow for WAIT_SIZE");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t state, state_nx;

  logic             abort_i;
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_empty, fifo_full;
  logic             push, pop;

  logic [SEL_W-1:0] cmd_sel_q;
  logic             cmd_rise_q;
  logic [31:0]      cmd_to_q;
  logic [31:0]      cnt_q;
  logic [31:0]      cnt_inc;
  logic [1:0]       status_q;
  logic             hit_timeout;

`ifdef WAIT_INIT_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);
  assign cmd_ready  = !fifo_full && !abort_i;
  assign push       = cmd_valid && cmd_ready;
  // Abort blocks the pop so a flushed FIFO never feeds the command register.
  assign pop        = (state == S_IDLE) && !fifo_empty && !abort_i;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_sel, cmd_rise, cmd_timeout};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Saturating increment; the counter must never wrap even with no timeout.
  assign cnt_inc     = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
  assign hit_timeout = (cmd_to_q != 32'd0) && (cnt_inc == cmd_to_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (pop) state_nx = S_ISSUE;
      S_ISSUE: state_nx = abort_i ? S_RESP : S_WAIT;
      S_WAIT:  if (abort_i || wait_done || hit_timeout) state_nx = S_RESP;
      S_RESP:  if (rsp_ready) state_nx = S_GAP;
      S_GAP:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    wait_en   = (state == S_WAIT);
    rsp_valid = (state == S_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_sel_q  <= '0;
      cmd_rise_q <= 1'b0;
      cmd_to_q   <= 32'd0;
      cnt_q      <= 32'd0;
      status_q   <= ST_DONE;
    end else begin
      if (pop) begin
        {cmd_sel_q, cmd_rise_q, cmd_to_q} <= mem[rd_ptr];
      end
      case (state)
        S_ISSUE: begin
          cnt_q <= 32'd0;
          if (abort_i) status_q <= ST_ABORT;
        end
        S_WAIT: begin
          cnt_q <= cnt_inc;
          // Priority: abort, then responder edge, then timeout.
          if (abort_i)          status_q <= ST_ABORT;
          else if (wait_done)   status_q <= ST_DONE;
          else if (hit_timeout) status_q <= ST_TIMEOUT;
        end
        default: ;
      endcase
    end
  end

  assign wait_sel    = cmd_sel_q;
  assign sel_wtr_wtf = cmd_rise_q;
  assign max_timeout = cmd_to_q;
  assign rsp_status  = status_q;
  assign rsp_sel     = cmd_sel_q;
  assign rsp_cycles  = cnt_q;

endmodule

// File: tb/tb_wait_event_initiator.sv
// tb/tb_wait_event_initiator.sv - scoreboard bench for wait_event_initiator with a modelled responder
module tb_wait_event_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_sel = '0;
  logic        cmd_rise = 1'b0;
  logic [31:0] cmd_timeout = '0;
  logic        wait_en;
  logic        sel_wtr_wtf;
  logic [31:0] max_timeout;
  logic [2:0]  wait_sel;
  logic        wait_done = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_status;
  logic [2:0]  rsp_sel;
  logic [31:0] rsp_cycles;
`ifdef WAIT_INIT_ABORT_EN
  logic        abort = 1'b0;
`endif

  wait_event_initiator #(.FIFO_DEPTH(4), .WAIT_SIZE(5), .SEL_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef WAIT_INIT_ABORT_EN
    .abort(abort),
`endif
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
    .cmd_rise(cmd_rise), .cmd_timeout(cmd_timeout),
    .wait_en(wait_en), .sel_wtr_wtf(sel_wtr_wtf), .max_timeout(max_timeout),
    .wait_sel(wait_sel), .wait_done(wait_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_sel(rsp_sel), .rsp_cycles(rsp_cycles)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] status; logic [2:0] sel; logic [31:0] cycles; } rsp_t;
  typedef struct { int done_at; logic [2:0] sel; logic rise; } wait_t;

  rsp_t sb_q[$];
  wait_t drv_q[$];
  int len_q[$];
  int passed = 0;
  int total = 0;
  bit stray = 1'b0;

  int k = 0;
  int lo = 0;
  bit seen = 1'b0;
  int cur_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic fail_evt(input string name);
    total++;
    $display("FAIL %s: event occurred, expected none", name);
  endtask

  // Responder model followed by the response monitor, in one block so ordering is fixed.
  always @(negedge clk) begin
    wait_t w;
    rsp_t e;
    if (!rst_n) begin
      k = 0; lo = 0; seen = 1'b0; cur_done = 0;
      wait_done = 1'b0;
      len_q.delete();
    end else begin
      if (wait_en) begin
        if (k == 0) begin
          if (drv_q.size() == 0) begin
            fail_evt("unexpected_wait_en");
            cur_done = 0;
          end else begin
            w = drv_q.pop_front();
            cur_done = w.done_at;
            chk("wait_sel", wait_sel, w.sel);
            chk("sel_wtr_wtf", sel_wtr_wtf, w.rise);
          end
          if (seen) chk("gap_low_ge4", lo >= 4, 1);
          seen = 1'b1;
        end
        k++;
        lo = 0;
        wait_done = (k == cur_done);
      end else begin
        if (k != 0) begin
          len_q.push_back(k);
          k = 0;
        end
        lo++;
        wait_done = stray;
      end
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) fail_evt("unexpected_rsp");
        else begin
          e = sb_q.pop_front();
          chk("rsp_status", rsp_status, e.status);
          chk("rsp_sel", rsp_sel, e.sel);
          chk("rsp_cycles", rsp_cycles, e.cycles);
          if (len_q.size() == 0) fail_evt("wait_len_missing");
          else chk("wait_en_high_cycles", len_q.pop_front(), e.cycles);
        end
      end
    end
  end

  task automatic push(input logic [2:0] sel, input logic rise, input logic [31:0] to,
                      input int done_at, input bit exp_rsp, input logic [1:0] st,
                      input logic [31:0] cyc);
    int n = 0;
    wait_t w;
    rsp_t r;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_sel = sel; cmd_rise = rise; cmd_timeout = to;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      fail_evt("push_timeout");
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    w.done_at = done_at; w.sel = sel; w.rise = rise;
    drv_q.push_back(w);
    if (exp_rsp) begin
      r.status = st; r.sel = sel; r.cycles = cyc;
      sb_q.push_back(r);
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb_q.size() != 0 || drv_q.size() != 0 || wait_en || rsp_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) fail_evt("drain_timeout");
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_wait_en", wait_en, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_status", rsp_status, 0);
    chk("reset_rsp_cycles", rsp_cycles, 0);
    chk("reset_max_timeout", max_timeout, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Done on WAIT cycle 7, plus push-to-wait_en latency and ISSUE-phase stability.
    push(3'd0, 1'b1, 32'd100, 7, 1'b1, 2'b00, 32'd7);
    @(posedge clk); #1;
    chk("issue_wait_en_low", wait_en, 0);
    chk("issue_max_timeout", max_timeout, 100);
    @(posedge clk); #1;
    chk("latency_wait_en_high", wait_en, 1);
    drain(200);

    // Timeout of 5 with no responder edge.
    push(3'd2, 1'b0, 32'd5, 0, 1'b1, 2'b01, 32'd5);
    @(posedge clk); #1;
    chk("issue_wait_sel", wait_sel, 2);
    chk("issue_sel_wtr_wtf", sel_wtr_wtf, 0);
    chk("issue_timeout5", max_timeout, 5);
    drain(200);

    // Done on the same cycle the timeout would fire.
    push(3'd1, 1'b1, 32'd5, 5, 1'b1, 2'b00, 32'd5);
    drain(200);

    // Short waits: 1-cycle done, timeout=1, timeout before a late done, long wait with no timeout.
    push(3'd4, 1'b1, 32'd0, 1, 1'b1, 2'b00, 32'd1);
    push(3'd3, 1'b1, 32'd1, 0, 1'b1, 2'b01, 32'd1);
    push(3'd5, 1'b0, 32'd2, 3, 1'b1, 2'b01, 32'd2);
    push(3'd1, 1'b0, 32'd0, 20, 1'b1, 2'b00, 32'd20);
    drain(400);

    // wait_done outside WAIT must be ignored.
    stray = 1'b1;
    repeat (6) @(negedge clk);
    chk("stray_wait_en", wait_en, 0);
    chk("stray_rsp_valid", rsp_valid, 0);
    stray = 1'b0;
    repeat (2) @(negedge clk);

    // Back-pressure: five commands while responses are held off.
    @(posedge clk); #1 rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(3'(i), 1'b1, 32'd0, i + 1, 1'b1, 2'b00, 32'(i + 1));
    end
    @(negedge clk);
    chk("full_cmd_ready", cmd_ready, 0);
    repeat (4) @(negedge clk);
    chk("held_rsp_valid", rsp_valid, 1);
    chk("held_rsp_sel", rsp_sel, 0);
    chk("held_rsp_cycles", rsp_cycles, 1);
    chk("held_cmd_ready", cmd_ready, 0);
    @(posedge clk); #1 rsp_ready = 1'b1;
    drain(400);

    // Reset during WAIT with a second command queued.
    push(3'd1, 1'b1, 32'd0, 0, 1'b0, 2'b00, 32'd0);
    push(3'd2, 1'b1, 32'd0, 0, 1'b0, 2'b00, 32'd0);
    begin
      int n = 0;
      while (!wait_en && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!wait_en) fail_evt("reset_test_no_wait");
    end
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("async_rst_wait_en", wait_en, 0);
    chk("async_rst_rsp_valid", rsp_valid, 0);
    chk("async_rst_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    drv_q.delete();
    sb_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_wait_en", wait_en, 0);
    chk("post_rst_rsp_valid", rsp_valid, 0);
    chk("post_rst_cmd_ready", cmd_ready, 1);

    push(3'd0, 1'b1, 32'd3, 2, 1'b1, 2'b00, 32'd2);
    drain(200);

`ifdef WAIT_INIT_ABORT_EN
    push(3'd0, 1'b1, 32'd0, 0, 1'b1, 2'b10, 32'd2);
    push(3'd1, 1'b1, 32'd0, 0, 1'b0, 2'b00, 32'd0);
    push(3'd2, 1'b1, 32'd0, 0, 1'b0, 2'b00, 32'd0);
    begin
      int n = 0;
      while (!wait_en && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    drv_q.delete();
    drain(200);
    chk("abort_no_wait_en", wait_en, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
